mix_columns_seq: RTL and testbench

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/mix_columns_seq.sv | 131 +++++++++++++
 tb/tb_mix_columns_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one column per cycle with valid/ready handshakes on both sides.
// Define MIX_COLUMNS_INV_EN to build InvMixColumns selected by a captured i_inverse.
module mix_columns_seq (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [127:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_bypass,
  input  logic         i_inverse,
  output logic [127:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic [1:0]   cnt;
  logic [127:0] work;
  logic [127:0] work_nxt;
  logic         byp;
  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [127:0] tmp;
  logic [127:0] mask;
  logic [127:0] ins;

  function automatic logic [7:0] x2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] x3(input logic [7:0] x);
    return x2(x) ^ x;
  endfunction

  // Column packed as {a0, a1, a2, a3}, a0 being row 0.
  function automatic logic [31:0] fwd_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {x2(a0) ^ x3(a1) ^ a2 ^ a3,
            a0 ^ x2(a1) ^ x3(a2) ^ a3,
            a0 ^ a1 ^ x2(a2) ^ x3(a3),
            x3(a0) ^ a1 ^ a2 ^ x2(a3)};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  logic inv;

  function automatic logic [7:0] m9(input logic [7:0] x);
    return x2(x2(x2(x))) ^ x;
  endfunction

  function automatic logic [7:0] m11(input logic [7:0] x);
    return x2(x2(x2(x))) ^ x2(x) ^ x;
  endfunction

  function automatic logic [7:0] m13(input logic [7:0] x);
    return x2(x2(x2(x))) ^ x2(x2(x)) ^ x;
  endfunction

  function automatic logic [7:0] m14(input logic [7:0] x);
    return x2(x2(x2(x))) ^ x2(x2(x)) ^ x2(x);
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3),
            m9(a0) ^ m14(a1) ^ m11(a2) ^ m13(a3),
            m13(a0) ^ m9(a1) ^ m14(a2) ^ m11(a3),
            m11(a0) ^ m13(a1) ^ m9(a2) ^ m14(a3)};
  endfunction

  always_comb col_out = inv ? inv_mix(col_in) : fwd_mix(col_in);
`else
  logic unused_inverse;
  assign unused_inverse = i_inverse;
  always_comb col_out = fwd_mix(col_in);
`endif

  // Shifting column cnt into the top byte of each row selects it without a mux tree.
  // NOTE: every always_comb output is fully assigned on each pass, so no latches can form.
  always_comb begin
    tmp      = work << {cnt, 3'b000};
    col_in   = {tmp[127:120], tmp[95:88], tmp[63:56], tmp[31:24]};
    mask     = {4{8'hff, 24'h0}} >> {cnt, 3'b000};
    ins      = {col_out[31:24], 24'h0, col_out[23:16], 24'h0,
                col_out[15:8], 24'h0, col_out[7:0], 24'h0} >> {cnt, 3'b000};
    work_nxt = (work & ~mask) | ins;
  end

  // NOTE: registered state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      work  <= 128'h0;
      byp   <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          work  <= i_data;
          byp   <= i_bypass;
`ifdef MIX_COLUMNS_INV_EN
          inv   <= i_inverse;
`endif
          cnt   <= 2'd0;
          state <= i_bypass ? DONE : BUSY;
        end
        BUSY: begin
          if (!byp) work <= work_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DONE;
        end
        DONE:    if (i_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_data  = work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq against a GF(2^8) matrix-multiply reference model.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [127:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic         i_bypass;
  logic         i_inverse;
  logic [127:0] o_data;
  logic         o_valid;
  logic         i_ready;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] VEC_IN  = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
  localparam logic [127:0] VEC_MIX = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;

  mix_columns_seq dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_bypass  (i_bypass),
    .i_inverse (i_inverse),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
  );

  always #5 clk = ~clk;

  // Generic shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix product per column; inverse only exists when the option is built.
  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv_req);
    logic [7:0]   coef [4];
    logic [127:0] r = 128'h0;
    logic [7:0]   acc;
    bit           inv_eff = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
    inv_eff = inv_req;
`endif
    if (inv_eff) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    else         coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - row + 4) % 4], s[127 - 32*k - 8*c -: 8]);
        r[127 - 32*row - 8*c -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents one state from an IDLE cycle, then counts edges from accept to o_valid (bounded).
  task automatic drive_and_wait(input logic [127:0] d, input bit byp, input bit inv,
                                input bit hold_valid, output int lat);
    i_data    = d;
    i_bypass  = byp;
    i_inverse = inv;
    i_valid   = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; i_valid = 1'b0; i_bypass = 1'b0; i_inverse = 1'b0;
    i_ready = 1'b0; i_data = 128'h0;
    #12;
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    n_tests++; if (o_data !== 128'h0) begin n_fail++; $display("FAIL reset_o_data got %h want 0", o_data); end
    n_rst = 1'b1;
    // Idle cycles with i_valid low must leave everything put.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 128'h0) begin
        n_fail++;
        $display("FAIL idle_hold got ready=%b valid=%b data=%h want 1 0 0", o_ready, o_valid, o_data);
      end
    end
  endtask

  task automatic test_forward();
    int lat;
    i_ready = 1'b1;
    drive_and_wait(VEC_IN, 1'b0, 1'b0, 1'b0, lat);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL fwd_latency got %0d want 5", lat); end
    n_tests++; if (o_data !== VEC_MIX) begin n_fail++; $display("FAIL fwd_data got %h want %h", o_data, VEC_MIX); end
    n_tests++; if (o_data !== mix_ref(VEC_IN, 1'b0)) begin n_fail++; $display("FAIL fwd_model got %h want %h", o_data, mix_ref(VEC_IN, 1'b0)); end
    @(posedge clk); #1;
    n_tests++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_to_idle got ready=%b valid=%b want 1 0", o_ready, o_valid); end
  endtask

  task automatic test_bypass();
    int lat;
    i_ready = 1'b1;
    drive_and_wait(VEC_IN, 1'b1, 1'b0, 1'b0, lat);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL byp_latency got %0d want 1", lat); end
    n_tests++; if (o_data !== VEC_IN) begin n_fail++; $display("FAIL byp_data got %h want %h", o_data, VEC_IN); end
    @(posedge clk); #1;
    n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL byp_to_idle got ready=%b want 1", o_ready); end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] d   = rnd128();
    logic [127:0] exp = mix_ref(d, 1'b0);
    i_ready = 1'b0;
    drive_and_wait(d, 1'b0, 1'b0, 1'b0, lat);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL bp_latency got %0d want 5", lat); end
    for (int i = 0; i < 10; i++) begin
      i_data = rnd128(); i_valid = 1'b1; i_bypass = i[0];
      @(posedge clk); #1;
      n_tests++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== exp) begin
        n_fail++;
        $display("FAIL bp_stall%0d got valid=%b ready=%b data=%h want 1 0 %h", i, o_valid, o_ready, o_data, exp);
      end
    end
    i_valid = 1'b0; i_bypass = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== exp) begin
      n_fail++;
      $display("FAIL bp_release got ready=%b valid=%b data=%h want 1 0 %h", o_ready, o_valid, o_data, exp);
    end
  endtask

  task automatic test_inverse();
    int lat;
    logic [127:0] exp = mix_ref(VEC_MIX, 1'b1);
    i_ready = 1'b1;
    drive_and_wait(VEC_MIX, 1'b0, 1'b1, 1'b0, lat);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL inv_latency got %0d want 5", lat); end
    n_tests++; if (o_data !== exp) begin n_fail++; $display("FAIL inv_data got %h want %h", o_data, exp); end
`ifdef MIX_COLUMNS_INV_EN
    n_tests++; if (o_data !== VEC_IN) begin n_fail++; $display("FAIL inv_vector got %h want %h", o_data, VEC_IN); end
`endif
    @(posedge clk); #1;
  endtask

  // i_valid stays high across handoffs: each handoff edge must only return to IDLE.
  task automatic test_back_to_back();
    int lat;
    logic [127:0] d   = rnd128();
    bit           byp = ($urandom_range(0, 3) == 0);
    bit           inv = $urandom_range(0, 1) == 1;
    logic [127:0] exp;
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp = byp ? d : mix_ref(d, inv);
      drive_and_wait(d, byp, inv, 1'b1, lat);
      n_tests++; if (lat !== (byp ? 1 : 5)) begin n_fail++; $display("FAIL b2b%0d_latency got %0d want %0d", k, lat, byp ? 1 : 5); end
      n_tests++; if (o_data !== exp) begin n_fail++; $display("FAIL b2b%0d_data got %h want %h", k, o_data, exp); end
      d   = rnd128();
      byp = ($urandom_range(0, 3) == 0);
      inv = $urandom_range(0, 1) == 1;
      i_data = d; i_bypass = byp; i_inverse = inv;
      @(posedge clk); #1;
      n_tests++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== exp) begin
        n_fail++;
        $display("FAIL b2b%0d_handoff got ready=%b valid=%b data=%h want 1 0 %h", k, o_ready, o_valid, o_data, exp);
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [127:0] d = rnd128();
    i_ready = 1'b1;
    i_data = d; i_bypass = 1'b0; i_inverse = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", o_valid); end
    n_tests++; if (o_data !== 128'h0) begin n_fail++; $display("FAIL rst_mid_data got %h want 0", o_data); end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got ready=%b valid=%b want 1 0", o_ready, o_valid); end
    d = rnd128();
    drive_and_wait(d, 1'b0, 1'b0, 1'b0, lat);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL rst_mid_latency got %0d want 5", lat); end
    n_tests++; if (o_data !== mix_ref(d, 1'b0)) begin n_fail++; $display("FAIL rst_mid_fresh got %h want %h", o_data, mix_ref(d, 1'b0)); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_bypass();
    test_backpressure();
    test_inverse();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
